// File: rtl/risc_mgmt_mem_resp.sv
// risc_mgmt_mem_resp: runs RISC-MGMT extension word accesses on the core's
// data-memory bus, sharing it with the pipeline's own data port. The core
// always has priority; the extension gets the bus only while the core is idle.
module risc_mgmt_mem_resp #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  // extension side
  input  logic        req_mem,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store,
  output logic [31:0] mem_load,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        mem_err,
  // pipeline data port
  input  logic        core_ren,
  input  logic        core_wen,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_byte_en,
  output logic [31:0] core_rdata,
  output logic        core_busy,
  // data-memory bus
  output logic        dbus_ren,
  output logic        dbus_wen,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_byte_en,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_busy
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_q;
  logic        ren_q, wen_q, err_q;
  logic [15:0] cnt_q;

  logic rv, bad_req, core_act, tmo_hit;

  assign rv       = req_mem & (mem_ren | mem_wen);
  assign bad_req  = (mem_addr[1:0] != 2'b00) | (mem_ren & mem_wen);
  assign core_act = core_ren | core_wen;
  // Fires on the wait cycle that would bring the count up to the limit.
  assign tmo_hit  = ({1'b0, cnt_q} + 17'd1) >= TMO;

  assign mem_load   = load_q;
  assign mem_done   = (state_q == DONE);
  assign mem_err    = err_q;
  assign core_rdata = dbus_rdata;

  // Next-state selection; error starts bypass the core-priority check.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rv) begin
              if (bad_req)        state_d = DONE;
              else if (!core_act) state_d = REQ;
            end
      REQ:  if (!dbus_busy || tmo_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus mux: pass-through from the core except while an extension access runs.
  always_comb begin
    dbus_ren     = core_ren;
    dbus_wen     = core_wen;
    dbus_addr    = core_addr;
    dbus_wdata   = core_wdata;
    dbus_byte_en = core_byte_en;
    core_busy    = dbus_busy;
    mem_busy     = 1'b0;
    case (state_q)
      IDLE: mem_busy = rv;
      REQ: begin
        dbus_ren     = ren_q;
        dbus_wen     = wen_q;
        dbus_addr    = addr_q;
        dbus_wdata   = wdata_q;
        dbus_byte_en = 4'hF;
        core_busy    = 1'b1;
        mem_busy     = 1'b1;
      end
      default: ;
    endcase
  end

  // State, holding registers, wait counter, error flag and load capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (rv) begin
          if (bad_req) begin
            err_q  <= 1'b1;
            load_q <= '0;
          end else if (!core_act) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_store;
            ren_q   <= mem_ren;
            wen_q   <= mem_wen;
            cnt_q   <= '0;
          end
        end
        REQ: begin
          if (!dbus_busy) begin
            // Writes report zero so stale read data never leaks out.
            load_q <= ren_q ? dbus_rdata : 32'h0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            if (tmo_hit) begin
              err_q  <= 1'b1;
              load_q <= '0;
              ren_q  <= 1'b0;
              wen_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
